tdma_tx_scheduler: RTL
======================

Name: tdma_tx_scheduler

Overview:
- Per-node TDMA transmit scheduler for the EER-RL cluster MAC.
- Tracks slot/frame timing after a cluster-head timeslot sync and gates the transmitter with okToSend only in this node's slot.
- Performs a clear-channel assessment (CCA), retries busy or unfinished slots in later frames, and drops data after MAX_RETRIES failures.
- Sits between the controller (myTimeslot, role, iHaveData) and the radio TX path (channel_clear, tx_done).

Parameters:
- WORD_WIDTH, 16, width of slot and frame fields.
- SLOT_CYCLES, 1000, clock cycles per timeslot (>= CCA_CYCLES+2).
- CCA_CYCLES, 4, consecutive clear samples required before sending.
- MAX_RETRIES, 3, failed attempts before a drop (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frameSync  in  1  pulse: CH timeslot packet received, current cycle becomes slot 0 / cycle 0.
- frameLength  in  WORD_WIDTH  slots per frame; 0 is treated as 1.
- myTimeslot  in  WORD_WIDTH  assigned member slot.
- role  in  1  1 = cluster head, which uses slot 0; 0 = member, which uses myTimeslot.
- iHaveData  in  1  level: data waiting.
- channel_clear  in  1  1 = medium idle.
- tx_done  in  1  pulse: transmitter finished the packet.
- okToSend  out  1  transmit grant (level).
- slotCount  out  WORD_WIDTH  current slot index.
- frameStart  out  1  pulse at each slot-0 boundary.
- txSuccess  out  1  pulse on completed send.
- txDrop  out  1  pulse when retries are exhausted.
- retryCount  out  4  failed attempts for the current data.
- synced  out  1  frame timing valid.
- slotInvalid  out  1  own slot >= effective frameLength.

Behaviour:
- All outputs are registered.
- Reset values: every output 0; state IDLE; pending, counters and synced cleared.
- Reset mid-operation drops okToSend the next cycle and loses pending data.
- cycleCnt counts 0..SLOT_CYCLES-1, then wraps and increments slotCount.
- slotCount wraps from effLen-1 to 0, where effLen = max(frameLength,1). frameStart pulses one cycle on that wrap.
- Counters are inactive while synced=0.
- frameSync takes priority over everything:
  - next cycle: cycleCnt=0, slotCount=0, synced=1, frameStart=1;
  - any CCA/SEND is aborted and state returns to WAIT_SLOT;
  - no retry is charged and pending is kept.
- pending: set on any cycle with iHaveData=1; cleared on txSuccess or txDrop. It re-arms the next cycle if iHaveData is still high.
- ownSlot = 0 if role=1, else myTimeslot. slotInvalid = synced & (ownSlot >= effLen). While slotInvalid=1, CCA is never entered.
- FSM states:
  - IDLE: waits for frameSync, then WAIT_SLOT.
  - WAIT_SLOT: if slotCount==ownSlot, cycleCnt==0 and pending, go to CCA. Otherwise stay.
  - CCA: samples channel_clear on cycleCnt 0..CCA_CYCLES-1.
    - Any 0 sample is a failure: go to WAIT_SLOT for the next frame's slot.
    - All samples 1: go to SEND; okToSend=1 from cycleCnt==CCA_CYCLES.
  - SEND: okToSend held high.
    - tx_done=1: okToSend=0, txSuccess pulse, retryCount=0, pending=0, then WAIT_SLOT.
    - Slot ends (cycleCnt wraps) before tx_done: okToSend=0 at the boundary, counted as a failure.
    - tx_done on the same cycle as the wrap counts as success.
    - tx_done outside SEND is ignored.
- Failure handling: retryCount increments on each failure. When it reaches MAX_RETRIES: txDrop pulses, retryCount=0, pending=0.
- A change to myTimeslot, role or frameLength takes effect at the next WAIT_SLOT evaluation. A change during SEND does not abort the send.

Test Plan:
Common setup unless stated: SLOT_CYCLES=8, CCA_CYCLES=2, MAX_RETRIES=3, frameLength=4, myTimeslot=2, role=0. Cycle N = N cycles after the frameSync cycle.
1. Reset, then frameSync, then iHaveData=1 held, channel_clear=1 -> cycle 1: synced=1, frameStart=1. Slot 2 begins at cycle 17. okToSend=1 at cycle 19. tx_done at cycle 21 -> okToSend=0, txSuccess=1 at cycle 22.
2. channel_clear=0 for all of slot 2 in 3 consecutive frames -> retryCount 1,2 and okToSend never asserted; after 3rd failure txDrop=1, retryCount=0.
3. CCA passes but no tx_done -> okToSend low at slot-2 end (cycle 25), retryCount=1; next frame succeeds -> txSuccess, retryCount=0.
4. frameSync during SEND -> okToSend=0 next cycle, slotCount=0, retryCount unchanged, send resumes in next slot 2.
5. role=1, myTimeslot=2 -> okToSend only within slot 0. Member with myTimeslot=5, frameLength=4 -> slotInvalid=1, no okToSend.
6. frameLength=0 -> effLen=1: frameStart every 8 cycles, slotCount stays 0.

Source files
------------

// File: rtl/tdma_tx_scheduler_if.sv
// Controller / radio-TX side bundle of the TDMA transmit scheduler.
// The master drives the controller and radio inputs. The slave is the scheduler.
interface tdma_tx_scheduler_if #(
   parameter int unsigned WORD_WIDTH = 16
);
   logic                  frameSync;
   logic [WORD_WIDTH-1:0] frameLength;
   logic [WORD_WIDTH-1:0] myTimeslot;
   logic                  role;
   logic                  iHaveData;
   logic                  channel_clear;
   logic                  tx_done;

   logic                  okToSend;
   logic [WORD_WIDTH-1:0] slotCount;
   logic                  frameStart;
   logic                  txSuccess;
   logic                  txDrop;
   logic [3:0]            retryCount;
   logic                  synced;
   logic                  slotInvalid;

   modport master (
      output frameSync, frameLength, myTimeslot, role, iHaveData, channel_clear, tx_done,
      input  okToSend, slotCount, frameStart, txSuccess, txDrop, retryCount, synced, slotInvalid
   );

   modport slave (
      input  frameSync, frameLength, myTimeslot, role, iHaveData, channel_clear, tx_done,
      output okToSend, slotCount, frameStart, txSuccess, txDrop, retryCount, synced, slotInvalid
   );
endinterface

// File: rtl/tdma_tx_scheduler.sv
// Per-node TDMA transmit scheduler: slot/frame timing after CH sync, CCA, and send gating.
// It also handles retries across frames and drops the data after MAX_RETRIES failures.
module tdma_tx_scheduler #(
   parameter int unsigned WORD_WIDTH  = 16,
   parameter int unsigned SLOT_CYCLES = 1000,
   parameter int unsigned CCA_CYCLES  = 4,
   parameter int unsigned MAX_RETRIES = 3
) (
   input  logic                clk,
   input  logic                rst,
   tdma_tx_scheduler_if.slave  bus
);

   localparam int unsigned CYCLE_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int unsigned RETRY_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT_SLOT, CCA, SEND} stateT;

   stateT               state;
   stateT               stateNext;
   logic [CYCLE_W-1:0]  cycleCnt;
   logic                pending;

   logic [WORD_WIDTH-1:0] effLen_c;
   logic [WORD_WIDTH-1:0] ownSlot_c;
   logic                  ownInvalid_c;
   logic                  slotWrap_c;
   logic                  frameWrap_c;
   logic                  slotStart_c;
   logic                  ccaActive_c;
   logic                  success_c;
   logic                  fail_c;
   logic                  drop_c;
   logic                  okToSendNext;
   logic                  pendingNext;
   logic [RETRY_W-1:0]    retryNext;

   // Slot geometry. The first CCA sample is taken in the WAIT_SLOT cycle that opens our slot.
   always_comb begin
      effLen_c     = (bus.frameLength == '0) ? WORD_WIDTH'(1) : bus.frameLength;
      ownSlot_c    = bus.role ? '0 : bus.myTimeslot;
      ownInvalid_c = (ownSlot_c >= effLen_c);
      slotWrap_c   = bus.synced && (cycleCnt == CYCLE_W'(SLOT_CYCLES - 1));
      frameWrap_c  = slotWrap_c && (bus.slotCount >= (effLen_c - WORD_WIDTH'(1)));
      slotStart_c  = (state == WAIT_SLOT) && pending && !ownInvalid_c &&
                     (bus.slotCount == ownSlot_c) && (cycleCnt == '0);
      ccaActive_c  = !bus.frameSync && ((state == CCA) || slotStart_c);
   end

   // State register and registered FSM outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pending        <= 1'b0;
         bus.okToSend   <= 1'b0;
         bus.txSuccess  <= 1'b0;
         bus.txDrop     <= 1'b0;
         bus.retryCount <= '0;
      end else begin
         state          <= stateNext;
         pending        <= pendingNext;
         bus.okToSend   <= okToSendNext;
         bus.txSuccess  <= success_c;
         bus.txDrop     <= drop_c;
         bus.retryCount <= retryNext;
      end
   end

   // Next state. frameSync aborts any attempt without charging a retry.
   always_comb begin
      stateNext = state;
      success_c = 1'b0;
      fail_c    = 1'b0;
      if (bus.frameSync) begin
         stateNext = WAIT_SLOT;
      end else begin
         case (state)
            IDLE: stateNext = IDLE;
            WAIT_SLOT, CCA: begin
               if (ccaActive_c) begin
                  if (!bus.channel_clear) begin
                     fail_c    = 1'b1;
                     stateNext = WAIT_SLOT;
                  end else if (cycleCnt == CYCLE_W'(CCA_CYCLES - 1)) begin
                     stateNext = SEND;
                  end else begin
                     stateNext = CCA;
                  end
               end
            end
            SEND: begin
               if (bus.tx_done) begin
                  success_c = 1'b1;
                  stateNext = WAIT_SLOT;
               end else if (slotWrap_c) begin
                  fail_c    = 1'b1;
                  stateNext = WAIT_SLOT;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Output next-values: grant follows SEND, and a completed or dropped attempt clears pending and retries.
   always_comb begin
      drop_c       = fail_c && (bus.retryCount == RETRY_W'(MAX_RETRIES - 1));
      okToSendNext = (stateNext == SEND);
      pendingNext  = pending;
      retryNext    = bus.retryCount;
      if (success_c || drop_c) begin
         pendingNext = 1'b0;
         retryNext   = '0;
      end else begin
         if (bus.iHaveData) pendingNext = 1'b1;
         if (fail_c) retryNext = bus.retryCount + RETRY_W'(1);
      end
   end

   // Slot/frame timing. It only runs once synced, and frameSync restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycleCnt        <= '0;
         bus.slotCount   <= '0;
         bus.synced      <= 1'b0;
         bus.frameStart  <= 1'b0;
         bus.slotInvalid <= 1'b0;
      end else begin
         bus.frameStart  <= 1'b0;
         bus.slotInvalid <= (bus.synced || bus.frameSync) && ownInvalid_c;
         if (bus.frameSync) begin
            cycleCnt       <= '0;
            bus.slotCount  <= '0;
            bus.synced     <= 1'b1;
            bus.frameStart <= 1'b1;
         end else if (bus.synced) begin
            if (slotWrap_c) begin
               cycleCnt <= '0;
               if (frameWrap_c) begin
                  bus.slotCount  <= '0;
                  bus.frameStart <= 1'b1;
               end else begin
                  bus.slotCount <= bus.slotCount + WORD_WIDTH'(1);
               end
            end else begin
               cycleCnt <= cycleCnt + CYCLE_W'(1);
            end
         end
      end
   end

endmodule
